lstm_gate_ctrl: RTL and testbench

Parametrised sequencer for one LSTM gate pass. It supersedes the per-gate I/F/O/C controllers with a single block that has a runtime gate select, VEC_LEN-element beat counting, a BRAM write address, an activation-mode select (sigmoid or tanh) and overrun/underrun error detection. It sits between the spmxv engine, the activation unit and the four gate BRAMs (I, F, O, C), and reports completion to the top-level LSTM scheduler.

---
 rtl/lstm_ctrl_pkg.sv | 30 +++
 rtl/ctrl_beat_cnt.sv | 42 ++++
 rtl/lstm_gate_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lstm_gate_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lstm_ctrl_pkg.sv
// lstm_ctrl_pkg: shared constants for the LSTM gate sequencer.
//   - gate encodings (I, F, O, C), in BRAM write-enable bit order
//   - activation mode encodings
//   - sequencer state type
package lstm_ctrl_pkg;

  localparam logic [1:0] GATE_I = 2'd0;
  localparam logic [1:0] GATE_F = 2'd1;
  localparam logic [1:0] GATE_O = 2'd2;
  localparam logic [1:0] GATE_C = 2'd3;

  localparam logic ACT_SIGMOID = 1'b0;
  localparam logic ACT_TANH    = 1'b1;

  typedef enum logic [2:0] {
    StRrr     = 3'd0,
    StStart   = 3'd1,
    StWaitAct = 3'd2,
    StStream  = 3'd3,
    StDrain   = 3'd4,
    StCwrite  = 3'd5,
    StStop    = 3'd6
  } state_e;

  // Activation mode for a latched gate: only the candidate (C) gate uses tanh.
  function automatic logic gate_act_mode(logic [1:0] gate);
    return (gate == GATE_C) ? ACT_TANH : ACT_SIGMOID;
  endfunction

endpackage

// File: rtl/ctrl_beat_cnt.sv
// ctrl_beat_cnt: saturating beat counter with synchronous active-low reset.
//   clk_i     clock, rising edge
//   rst_ni    synchronous reset, active-low
//   clr_i     clear to zero (priority over inc_i)
//   inc_i     increment request; ignored once the count reaches MaxCount
//   count_o   current count
//   at_max_o  count == MaxCount
module ctrl_beat_cnt #(
  parameter int unsigned MaxCount = 128,
  parameter int unsigned CntW     = $clog2(MaxCount + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [CntW-1:0] count_o,
  output logic            at_max_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == CntW'(MaxCount));
  assign count_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lstm_gate_ctrl.sv
// lstm_gate_ctrl: sequencer for one LSTM gate pass (I, F, O or C).
//   clk          system clock, rising edge
//   rst          synchronous reset, active-low
//   idle         start/restart pulse, overrides every state
//   gate_sel     gate to compute, latched while idle=1
//   spv_dateout  one spmxv output element valid
//   act_dateout  one activation output element valid
//   act_idle     activation unit enable
//   act_mode     0=sigmoid, 1=tanh (C gate only)
//   bram_wea     one-hot write enable of the latched gate's BRAM
//   bram_addr    write address aligned with bram_wea
//   done         pass complete, held until next idle/reset
//   err          sticky protocol error (overrun/underrun/stray beat)
module lstm_gate_ctrl
  import lstm_ctrl_pkg::*;
#(
  parameter int unsigned VEC_LEN = 128,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned N_GATES = 4,
  parameter int unsigned CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               idle,
  input  logic [1:0]         gate_sel,
  input  logic               spv_dateout,
  input  logic               act_dateout,
  output logic               act_idle,
  output logic               act_mode,
  output logic [N_GATES-1:0] bram_wea,
  output logic [ADDR_W-1:0]  bram_addr,
  output logic               done,
  output logic               err
);

  state_e              state_q, state_d;
  logic [1:0]          gate_q, gate_d;
  logic                act_idle_q, act_idle_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [N_GATES-1:0]  wea_q, wea_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic [CNT_W-1:0]    spv_cnt, wr_cnt;
  logic                spv_at_max, wr_at_max;
  logic                spv_win, act_win, act_legal;
  logic                spv_inc, wr_inc;

  always_comb begin
    spv_win   = state_q inside {StStart, StWaitAct, StStream, StDrain};
    act_win   = state_q inside {StWaitAct, StStream, StDrain};
    // Compared on registered counts, before this cycle's increments.
    act_legal = act_win && (wr_cnt < spv_cnt);
    spv_inc   = !idle && spv_dateout && spv_win;
    wr_inc    = !idle && act_dateout && act_legal;
  end

  ctrl_beat_cnt #(
    .MaxCount (VEC_LEN),
    .CntW     (CNT_W)
  ) u_spv_cnt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_i    (idle),
    .inc_i    (spv_inc),
    .count_o  (spv_cnt),
    .at_max_o (spv_at_max)
  );

  ctrl_beat_cnt #(
    .MaxCount (VEC_LEN),
    .CntW     (CNT_W)
  ) u_wr_cnt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_i    (idle),
    .inc_i    (wr_inc),
    .count_o  (wr_cnt),
    .at_max_o (wr_at_max)
  );

  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    act_idle_d = act_idle_q;
    done_d     = done_q;
    err_d      = err_q;
    wea_d      = '0;
    addr_d     = addr_q;

    if (idle) begin
      state_d    = StStart;
      gate_d     = gate_sel;
      act_idle_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      addr_d     = '0;
    end else begin
      unique case (state_q)
        StRrr: ;
        StStart: begin
          if (spv_dateout) begin
            state_d    = StWaitAct;
            act_idle_d = 1'b1;
          end
        end
        StWaitAct: begin
          if (act_dateout) state_d = StStream;
        end
        StStream: begin
          if (spv_at_max) state_d = StDrain;
        end
        StDrain: begin
          if (wr_at_max) state_d = StCwrite;
        end
        StCwrite: begin
          done_d     = 1'b1;
          act_idle_d = 1'b0;
          state_d    = StStop;
        end
        StStop: ;
        default: state_d = StRrr;
      endcase

      // Overrun from spmxv, or any beat after the pass has finished.
      if (spv_dateout && ((spv_win && spv_at_max) || (state_q == StStop))) begin
        err_d = 1'b1;
      end
      // Activation output before spmxv fed it, or stray beats at start/stop.
      if (act_dateout &&
          ((state_q == StStart) || (state_q == StStop) || (act_win && !act_legal))) begin
        err_d = 1'b1;
      end

      if (wr_inc) begin
        wea_d  = N_GATES'(1) << gate_q;
        addr_d = ADDR_W'(wr_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StRrr;
      gate_q     <= '0;
      act_idle_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wea_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      act_idle_q <= act_idle_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wea_q      <= wea_d;
      addr_q     <= addr_d;
    end
  end

  assign act_idle  = act_idle_q;
  assign act_mode  = gate_act_mode(gate_q);
  assign bram_wea  = wea_q;
  assign bram_addr = addr_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lstm_gate_ctrl.sv
// Bench for lstm_gate_ctrl with VEC_LEN=4. Cycle n starts 1 time unit after
// the n-th rising edge following reset; inputs change there, outputs are
// sampled on the falling edge inside the same cycle.
module tb_lstm_gate_ctrl;

  localparam int unsigned VEC_LEN = 4;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned N_GATES = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               idle;
  logic [1:0]         gate_sel;
  logic               spv_dateout;
  logic               act_dateout;
  logic               act_idle;
  logic               act_mode;
  logic [N_GATES-1:0] bram_wea;
  logic [ADDR_W-1:0]  bram_addr;
  logic               done;
  logic               err;

  always #5 clk = ~clk;

  lstm_gate_ctrl #(
    .VEC_LEN (VEC_LEN),
    .ADDR_W  (ADDR_W),
    .N_GATES (N_GATES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .idle        (idle),
    .gate_sel    (gate_sel),
    .spv_dateout (spv_dateout),
    .act_dateout (act_dateout),
    .act_idle    (act_idle),
    .act_mode    (act_mode),
    .bram_wea    (bram_wea),
    .bram_addr   (bram_addr),
    .done        (done),
    .err         (err)
  );

  typedef struct {
    logic [N_GATES-1:0] wea;
    logic [ADDR_W-1:0]  addr;
  } wr_t;

  typedef struct {
    logic [1:0]         gate;
    logic               mode;
    logic [N_GATES-1:0] wea;
    int                 extra_spv;  // cycle of an extra spv beat, -1 none
    int                 early_act;  // cycle of an extra act beat, -1 none
    int                 err_cyc;    // first cycle err is expected high, -1 never
  } vec_t;

  wr_t  sb_q[$];
  vec_t tbl[5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string nm, int c, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, got, exp);
    end
  endtask

  // Every DUT write must match the oldest expected write.
  task automatic sb_pop(int c);
    wr_t w;
    if (bram_wea !== '0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_write cycle %0d: got wea %0h expected none", c, bram_wea);
      end else begin
        w = sb_q.pop_front();
        chk("sb_wea", c, 32'(bram_wea), 32'(w.wea));
        chk("sb_addr", c, 32'(bram_addr), 32'(w.addr));
      end
    end
  endtask

  task automatic push(logic [N_GATES-1:0] wea, int addr);
    wr_t w;
    w.wea  = wea;
    w.addr = ADDR_W'(addr);
    sb_q.push_back(w);
  endtask

  task automatic drive(logic r, logic i, logic [1:0] g, logic s, logic a);
    rst         = r;
    idle        = i;
    gate_sel    = g;
    spv_dateout = s;
    act_dateout = a;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    next_cycle();
    sb_q.delete();
  endtask

  task automatic chk_all_zero(int c);
    chk("z_act_idle", c, 32'(act_idle), 0);
    chk("z_act_mode", c, 32'(act_mode), 0);
    chk("z_wea", c, 32'(bram_wea), 0);
    chk("z_addr", c, 32'(bram_addr), 0);
    chk("z_done", c, 32'(done), 0);
    chk("z_err", c, 32'(err), 0);
  endtask

  initial begin
    tbl[0] = '{gate: 2'd2, mode: 1'b0, wea: 4'b0100, extra_spv: -1, early_act: -1, err_cyc: -1};
    tbl[1] = '{gate: 2'd3, mode: 1'b1, wea: 4'b1000, extra_spv: -1, early_act: -1, err_cyc: -1};
    tbl[2] = '{gate: 2'd2, mode: 1'b0, wea: 4'b0100, extra_spv: 6,  early_act: -1, err_cyc: 7};
    tbl[3] = '{gate: 2'd2, mode: 1'b0, wea: 4'b0100, extra_spv: -1, early_act: 1,  err_cyc: 2};
    tbl[4] = '{gate: 2'd1, mode: 1'b0, wea: 4'b0010, extra_spv: -1, early_act: -1, err_cyc: -1};

    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero(-1);

    // Table-driven full passes: idle @0, spv @2-5, act @6-9.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int c = 0; c < 16; c++) begin
        logic s, a;
        int   e_addr;
        s = ((c >= 2) && (c <= 5)) || (c == tbl[v].extra_spv);
        a = ((c >= 6) && (c <= 9)) || (c == tbl[v].early_act);
        drive(1'b1, c == 0, tbl[v].gate, s, a);
        if ((c >= 6) && (c <= 9)) push(tbl[v].wea, c - 6);
        e_addr = (c < 7) ? 0 : ((c <= 10) ? c - 7 : 3);
        @(negedge clk);
        sb_pop(c);
        chk("act_idle", c, 32'(act_idle), 32'((c >= 3) && (c <= 11)));
        chk("act_mode", c, 32'(act_mode), (c >= 1) ? 32'(tbl[v].mode) : 0);
        chk("wea", c, 32'(bram_wea), ((c >= 7) && (c <= 10)) ? 32'(tbl[v].wea) : 0);
        chk("addr", c, 32'(bram_addr), 32'(e_addr));
        chk("done", c, 32'(done), 32'(c >= 12));
        chk("err", c, 32'(err), 32'((tbl[v].err_cyc >= 0) && (c >= tbl[v].err_cyc)));
        next_cycle();
      end
      chk("sb_drained", v, 32'(sb_q.size()), 0);
    end

    // idle re-pulsed mid-stream with gate 0, then a fresh pass.
    do_reset();
    for (int c = 0; c < 23; c++) begin
      logic s, a;
      s = ((c >= 2) && (c <= 5)) || ((c >= 10) && (c <= 13));
      a = (c == 6) || (c == 7) || ((c >= 14) && (c <= 17));
      drive(1'b1, (c == 0) || (c == 8), (c < 8) ? 2'd2 : 2'd0, s, a);
      if ((c == 6) || (c == 7)) push(4'b0100, c - 6);
      if ((c >= 14) && (c <= 17)) push(4'b0001, c - 14);
      @(negedge clk);
      sb_pop(c);
      if (c == 8) chk("rp_wea_pre", c, 32'(bram_wea), 32'(4'b0100));
      if (c == 9) chk_all_zero(c);
      if ((c >= 15) && (c <= 18)) begin
        chk("rp_wea", c, 32'(bram_wea), 32'(4'b0001));
        chk("rp_addr", c, 32'(bram_addr), 32'(c - 15));
      end
      if (c == 19) chk("rp_done_low", c, 32'(done), 0);
      if (c == 20) chk("rp_done", c, 32'(done), 1);
      if (c == 22) chk("rp_err", c, 32'(err), 0);
      next_cycle();
    end
    chk("rp_sb_drained", 23, 32'(sb_q.size()), 0);

    // Reset asserted mid-stream; later beats ignored while in RRR.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      logic s, a;
      s = ((c >= 2) && (c <= 5)) || ((c >= 8) && (c <= 11));
      a = (c >= 6) && (c <= 11);
      drive(c != 7, c == 0, 2'd2, s, a);
      if (c == 6) push(4'b0100, 0);
      @(negedge clk);
      sb_pop(c);
      if (c == 7) chk("rs_wea_pre", c, 32'(bram_wea), 32'(4'b0100));
      if (c >= 8) chk_all_zero(c);
      next_cycle();
    end
    chk("rs_sb_drained", 14, 32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
